// File: rtl/sba_bus_arbiter.sv
// sba_bus_arbiter: shares one system-bus slave between the core data
// port (m0) and the debug SBA master (m1) with one outstanding txn.
module sba_bus_arbiter #(
   parameter bit          ROUND_ROBIN    = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic [31:0] m0_rdata_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic [31:0] m1_rdata_o,
   output logic        m1_err_o,
   output logic        s_req_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic [31:0] s_rdata_i,
   input  logic        s_err_i
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP
   } state_e;

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
   localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);

   state_e      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] cnt_q, cnt_d;

   logic        winner;
   logic        sel;
   logic        sel_req;
   logic        drive;
   logic        gnt;
   logic        rsp_v;
   logic        rsp_e;
   logic [31:0] rsp_d;

   always_comb begin
      if (m0_req_i && m1_req_i) begin
         winner = ROUND_ROBIN ? ~last_q : 1'b1;
      end else begin
         winner = m1_req_i;
      end
   end

   // In ADDR the owner is locked; only IDLE re-arbitrates.
   assign sel     = (state_q == IDLE) ? winner : owner_q;
   assign sel_req = sel ? m1_req_i : m0_req_i;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      drive   = 1'b0;
      gnt     = 1'b0;
      rsp_v   = 1'b0;
      rsp_e   = 1'b0;
      rsp_d   = '0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (sel_req) begin
                  drive   = 1'b1;
                  gnt     = s_gnt_i;
                  owner_d = winner;
                  if (s_gnt_i) begin
                     last_d  = winner;
                     cnt_d   = '0;
                     state_d = RESP;
                  end else begin
                     state_d = ADDR;
                  end
               end
            end
            ADDR: begin
               if (sel_req) begin
                  drive = 1'b1;
                  gnt   = s_gnt_i;
                  if (s_gnt_i) begin
                     last_d  = owner_q;
                     cnt_d   = '0;
                     state_d = RESP;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            RESP: begin
               if (s_rvalid_i) begin
                  rsp_v   = 1'b1;
                  rsp_e   = s_err_i;
                  rsp_d   = s_rdata_i;
                  state_d = IDLE;
               end else if (TO_EN && (cnt_q == TO_LIM)) begin
                  rsp_v   = 1'b1;
                  rsp_e   = 1'b1;
                  state_d = IDLE;
               end else if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_req_o   = drive;
   assign s_we_o    = drive & (sel ? m1_we_i : m0_we_i);
   assign s_be_o    = drive ? (sel ? m1_be_i : m0_be_i) : 4'h0;
   assign s_addr_o  = drive ? (sel ? m1_addr_i : m0_addr_i) : 32'h0;
   assign s_wdata_o = drive ? (sel ? m1_wdata_i : m0_wdata_i) : 32'h0;

   // Grants follow the selected master; responses only the owner.
   assign m0_gnt_o    = gnt & ~sel;
   assign m1_gnt_o    = gnt & sel;
   assign m0_rvalid_o = rsp_v & ~owner_q;
   assign m1_rvalid_o = rsp_v & owner_q;
   assign m0_err_o    = rsp_e & ~owner_q;
   assign m1_err_o    = rsp_e & owner_q;
   assign m0_rdata_o  = (rsp_v && !owner_q) ? rsp_d : 32'h0;
   assign m1_rdata_o  = (rsp_v && owner_q) ? rsp_d : 32'h0;

endmodule

// File: tb/tb_sba_bus_arbiter.sv
// Bench for sba_bus_arbiter: round-robin and fixed-priority copies
// driven by directed and random traffic against a reference model.
module tb_sba_bus_arbiter;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   bit   chk_en = 1'b0;
   always #5 clk = ~clk;

   logic        req   [2][2];
   logic        we    [2][2];
   logic [3:0]  be    [2][2];
   logic [31:0] addr  [2][2];
   logic [31:0] wdata [2][2];
   logic        gnt   [2][2];
   logic        rvld  [2][2];
   logic [31:0] rdata [2][2];
   logic        err   [2][2];
   logic        s_req   [2];
   logic        s_we    [2];
   logic [3:0]  s_be    [2];
   logic [31:0] s_addr  [2];
   logic [31:0] s_wdata [2];
   logic        s_gnt   [2];
   logic        s_rvalid[2];
   logic        s_err   [2];
   logic [31:0] s_rdata [2];

   for (genvar k = 0; k < 2; k++) begin : g_dut
      sba_bus_arbiter #(
         .ROUND_ROBIN   (k == 0),
         .TIMEOUT_CYCLES(TO)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .m0_req_i   (req[k][0]),
         .m0_gnt_o   (gnt[k][0]),
         .m0_rvalid_o(rvld[k][0]),
         .m0_we_i    (we[k][0]),
         .m0_be_i    (be[k][0]),
         .m0_addr_i  (addr[k][0]),
         .m0_wdata_i (wdata[k][0]),
         .m0_rdata_o (rdata[k][0]),
         .m0_err_o   (err[k][0]),
         .m1_req_i   (req[k][1]),
         .m1_gnt_o   (gnt[k][1]),
         .m1_rvalid_o(rvld[k][1]),
         .m1_we_i    (we[k][1]),
         .m1_be_i    (be[k][1]),
         .m1_addr_i  (addr[k][1]),
         .m1_wdata_i (wdata[k][1]),
         .m1_rdata_o (rdata[k][1]),
         .m1_err_o   (err[k][1]),
         .s_req_o    (s_req[k]),
         .s_gnt_i    (s_gnt[k]),
         .s_rvalid_i (s_rvalid[k]),
         .s_we_o     (s_we[k]),
         .s_be_o     (s_be[k]),
         .s_addr_o   (s_addr[k]),
         .s_wdata_o  (s_wdata[k]),
         .s_rdata_i  (s_rdata[k]),
         .s_err_i    (s_err[k])
      );
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: mode 0 free, 1 bus locked to a master, 2 awaiting
   // the response, which is due no later than cycle m_dl.
   int     m_mode [2] = '{0, 0};
   int     m_own  [2] = '{0, 0};
   int     m_last [2] = '{1, 1};
   longint m_dl   [2] = '{0, 0};
   longint cyc = 0;
   bit     gseen  [2][2];

   task automatic model(input int k, output logic [139:0] e);
      logic        bq, bw;
      logic [3:0]  bb;
      logic [31:0] ba, bd;
      logic [1:0]  g, v, er;
      logic [31:0] rd [2];
      int          o, w;
      bq = 0; bw = 0; bb = 0; ba = 0; bd = 0;
      g = 0; v = 0; er = 0; rd[0] = 0; rd[1] = 0;
      if (!rst_n) begin
         m_mode[k] = 0;
         m_own[k]  = 0;
         m_last[k] = 1;
      end else begin
         if (m_mode[k] == 0 && (req[k][0] || req[k][1])) begin
            if (req[k][0] && req[k][1]) w = (k == 0) ? 1 - m_last[k] : 1;
            else w = req[k][1] ? 1 : 0;
            m_own[k]  = w;
            m_mode[k] = 1;
         end
         o = m_own[k];
         if (m_mode[k] == 1) begin
            if (req[k][o]) begin
               bq = 1; bw = we[k][o]; bb = be[k][o];
               ba = addr[k][o]; bd = wdata[k][o];
               g[o] = s_gnt[k];
               if (s_gnt[k]) begin
                  m_mode[k] = 2;
                  m_last[k] = o;
                  m_dl[k]   = cyc + 1 + TO;
               end
            end else begin
               m_mode[k] = 0;
            end
         end else if (m_mode[k] == 2) begin
            if (s_rvalid[k]) begin
               v[o] = 1; er[o] = s_err[k]; rd[o] = s_rdata[k];
               m_mode[k] = 0;
            end else if (cyc == m_dl[k]) begin
               v[o] = 1; er[o] = 1;
               m_mode[k] = 0;
            end
         end
      end
      gseen[k][0] = g[0];
      gseen[k][1] = g[1];
      e = {bq, bw, bb, ba, bd, g, v, er, rd[1], rd[0]};
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            logic [139:0] e, a;
            model(k, e);
            a = {s_req[k], s_we[k], s_be[k], s_addr[k], s_wdata[k],
                 gnt[k][1], gnt[k][0], rvld[k][1], rvld[k][0],
                 err[k][1], err[k][0], rdata[k][1], rdata[k][0]};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL model%0d cyc=%0d: got %h want %h",
                        k, cyc, a, e);
            end
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mreq(input int x, input bit r, input logic [31:0] a);
      for (int k = 0; k < 2; k++) begin
         req[k][x]   = r;
         we[k][x]    = a[0];
         be[k][x]    = a[7:4];
         addr[k][x]  = a;
         wdata[k][x] = ~a;
      end
   endtask

   task automatic slv(input bit g, input bit v, input logic [31:0] d,
                      input bit e);
      for (int k = 0; k < 2; k++) begin
         s_gnt[k]    = g;
         s_rvalid[k] = v;
         s_rdata[k]  = d;
         s_err[k]    = e;
      end
   endtask

   task automatic new_req(input int k, input int x);
      req[k][x]   = 1'b1;
      we[k][x]    = 1'($urandom);
      be[k][x]    = 4'($urandom);
      addr[k][x]  = $urandom;
      wdata[k][x] = $urandom;
   endtask

   int         ng [2];
   logic [3:0] gs [2];

   initial begin
      mreq(0, 0, 0);
      mreq(1, 0, 0);
      slv(0, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      step();
      @(negedge clk);
      chk("rst_sreq", s_req[0], 0);
      chk("rst_m0gnt", gnt[0][0], 0);
      // single read from master 0
      step();
      rst_n = 1'b1;
      mreq(0, 1, 32'h1000_0000);
      slv(1, 0, 0, 0);
      @(negedge clk);
      chk("rd_m0gnt", gnt[0][0], 1);
      chk("rd_saddr", s_addr[0], 32'h1000_0000);
      chk("rd_m1gnt", gnt[0][1], 0);
      step();
      mreq(0, 0, 0);
      slv(0, 1, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      chk("rd_m0rv", rvld[0][0], 1);
      chk("rd_m0rdata", rdata[0][0], 32'hDEAD_BEEF);
      chk("rd_m1rv", rvld[0][1], 0);
      chk("rd_m1rdata", rdata[0][1], 0);
      step();
      slv(0, 0, 0, 0);
      rst_n = 1'b0;
      // contention, zero-wait slave, from reset
      step();
      rst_n = 1'b1;
      mreq(0, 1, 32'h0000_00A0);
      mreq(1, 1, 32'h0000_00B0);
      slv(1, 1, 32'h1234, 0);
      ng[0] = 0; ng[1] = 0; gs[0] = 0; gs[1] = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (gnt[k][0] || gnt[k][1]) begin
               if (ng[k] < 4) gs[k][ng[k]] = gnt[k][1];
               ng[k]++;
            end
         end
         step();
      end
      chk("rr_order", 32'(gs[0]), 32'hA);
      chk("fp_order", 32'(gs[1]), 32'hF);
      chk("rr_count", ng[0], 4);
      chk("fp_count", ng[1], 4);
      mreq(0, 0, 0);
      mreq(1, 0, 0);
      slv(0, 0, 0, 0);
      step();
      // slave stall with master 1 arriving mid-stall
      mreq(0, 1, 32'h0000_00A0);
      @(negedge clk);
      chk("st_addr0", s_addr[0], 32'hA0);
      step();
      mreq(1, 1, 32'h0000_00B0);
      @(negedge clk);
      chk("st_addr1", s_addr[0], 32'hA0);
      chk("st_fp_addr", s_addr[1], 32'hA0);
      chk("st_fp_m1gnt", gnt[1][1], 0);
      step();
      @(negedge clk);
      chk("st_addr2", s_addr[0], 32'hA0);
      step();
      slv(1, 0, 0, 0);
      @(negedge clk);
      chk("st_fp_m0gnt", gnt[1][0], 1);
      chk("st_fp_m1gnt2", gnt[1][1], 0);
      step();
      mreq(0, 0, 0);
      slv(1, 1, 32'h55, 0);
      @(negedge clk);
      chk("st_resp_m1gnt", gnt[0][1], 0);
      chk("st_m0rv", rvld[0][0], 1);
      chk("st_m0rdata", rdata[0][0], 32'h55);
      step();
      slv(1, 0, 0, 0);
      @(negedge clk);
      chk("st_m1gnt", gnt[0][1], 1);
      chk("st_m1addr", s_addr[0], 32'hB0);
      step();
      // timeout after master 1's grant
      mreq(1, 0, 0);
      slv(0, 0, 0, 0);
      for (int c = 0; c < TO; c++) begin
         @(negedge clk);
         chk("to_early", rvld[0][1], 0);
         step();
      end
      @(negedge clk);
      chk("to_rv", rvld[0][1], 1);
      chk("to_err", err[0][1], 1);
      chk("to_rdata", rdata[0][1], 0);
      chk("to_fp_rv", rvld[1][1], 1);
      step();
      step();
      slv(0, 1, 32'h77, 1);
      @(negedge clk);
      chk("late_m1rv", rvld[0][1], 0);
      chk("late_m0rv", rvld[0][0], 0);
      step();
      slv(0, 0, 0, 0);
      // owner drops its request in ADDR
      mreq(0, 1, 32'h0000_00C0);
      @(negedge clk);
      chk("drop_sreq0", s_req[0], 1);
      step();
      mreq(0, 0, 0);
      mreq(1, 1, 32'h0000_00D0);
      @(negedge clk);
      chk("drop_sreq", s_req[0], 0);
      chk("drop_m1gnt0", gnt[0][1], 0);
      step();
      slv(1, 0, 0, 0);
      @(negedge clk);
      chk("drop_m1gnt", gnt[0][1], 1);
      chk("drop_addr", s_addr[0], 32'hD0);
      step();
      mreq(1, 0, 0);
      slv(0, 1, 32'h99, 0);
      step();
      // reset while a response is pending
      mreq(0, 1, 32'h0000_00E0);
      slv(1, 0, 0, 0);
      step();
      mreq(0, 0, 0);
      rst_n = 1'b0;
      slv(0, 1, 32'h66, 0);
      @(negedge clk);
      chk("rst_m0rv", rvld[0][0], 0);
      chk("rst_m0rdata", rdata[0][0], 0);
      step();
      rst_n = 1'b1;
      mreq(0, 1, 32'h0000_00F0);
      mreq(1, 1, 32'h0000_00F4);
      slv(1, 0, 0, 0);
      @(negedge clk);
      chk("rst_rr_m0gnt", gnt[0][0], 1);
      chk("rst_rr_m1gnt", gnt[0][1], 0);
      chk("rst_fp_m1gnt", gnt[1][1], 1);
      step();
      mreq(0, 0, 0);
      mreq(1, 0, 0);
      slv(0, 0, 0, 0);
      step();
      // random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(199, 0) != 0);
         for (int k = 0; k < 2; k++) begin
            for (int x = 0; x < 2; x++) begin
               if (req[k][x] && gseen[k][x]) begin
                  if ($urandom_range(1, 0) == 1) new_req(k, x);
                  else req[k][x] = 1'b0;
               end else if (req[k][x]) begin
                  if ($urandom_range(15, 0) == 0) req[k][x] = 1'b0;
               end else if ($urandom_range(2, 0) == 0) begin
                  new_req(k, x);
               end
            end
            s_gnt[k]    = 1'($urandom);
            s_rvalid[k] = ($urandom_range(2, 0) == 0);
            s_rdata[k]  = $urandom;
            s_err[k]    = ($urandom_range(3, 0) == 0);
         end
         step();
      end
      rst_n = 1'b1;
      mreq(0, 0, 0);
      mreq(1, 0, 0);
      slv(0, 0, 0, 0);
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sba_bus_arbiter.md
# sba_bus_arbiter

Two-master, one-slave arbiter that shares the system memory bus between the core data port (master 0) and the debug module's system-bus-access master (master 1). It sits between those two request/grant/rvalid master ports and the single bus slave port. It tracks the single outstanding transaction so the response goes back to the correct master. A response timeout keeps a hung slave from locking out the debugger.

## Interface
Parameters:
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = fixed priority, master 1 (debug) wins.
- TIMEOUT_CYCLES, 255: RESP-state cycles without s_rvalid_i before a synthesized error response; 0 disables; max 65535.

Ports (x = 0, 1):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mx_req_i  in  1  master x request
- mx_gnt_o  out  1  master x grant
- mx_rvalid_o  out  1  master x response valid
- mx_we_i  in  1  master x write enable
- mx_be_i  in  4  master x byte enables
- mx_addr_i  in  32  master x address
- mx_wdata_i  in  32  master x write data
- mx_rdata_o  out  32  master x read data
- mx_err_o  out  1  master x response error
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_rvalid_i  in  1  slave response valid
- s_we_o  out  1  slave write enable
- s_be_o  out  4  slave byte enables
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_rdata_i  in  32  slave read data
- s_err_i  in  1  slave error

## Operation
- Registers:
  - state: IDLE, ADDR or RESP.
  - owner: 1 bit.
  - last: 1 bit; last master granted.
  - cnt: 16 bits.
- Winner selection:
  - Only one requester: that master wins.
  - Both request, ROUND_ROBIN=1: the master not equal to last wins.
  - Both request, ROUND_ROBIN=0: master 1 wins.
- IDLE:
  - Slave signals carry the winner's req/we/be/addr/wdata combinationally.
  - The winner's mx_gnt_o equals s_gnt_i.
  - With s_gnt_i=1: owner<=winner, last<=winner, cnt<=0, go to RESP.
  - With s_gnt_i=0 and a request pending: owner<=winner, go to ADDR. Owner is locked and there is no re-arbitration.
  - No request: all slave outputs are 0.
- ADDR:
  - Drive the owner's fields; mx_gnt_o[owner]=s_gnt_i.
  - On s_gnt_i: last<=owner, cnt<=0, go to RESP.
  - If the owner drops its req (e.g. during ndmreset): s_req_o=0, return to IDLE. No transaction is issued.
- RESP:
  - s_req_o=0; both grants are 0. A competing request waits.
  - On s_rvalid_i: mx_rvalid_o[owner]=1, mx_rdata_o[owner]=s_rdata_i, mx_err_o[owner]=s_err_i; go to IDLE.
  - Else, if TIMEOUT_CYCLES!=0 and cnt==TIMEOUT_CYCLES: mx_rvalid_o[owner]=1, mx_err_o[owner]=1, mx_rdata_o[owner]=0; go to IDLE.
  - Otherwise cnt increments; it saturates and does not wrap.
- Responses and grants are only ever routed to the owner. The non-owner's rvalid/rdata/err/gnt are always 0.
- s_rvalid_i arriving in IDLE or ADDR (a late response after a timeout) is discarded and reaches no master.
- Reset (async, any state): state=IDLE, owner=0, last=1, cnt=0.
  - All outputs are 0 while rst_n=0 and in IDLE with no request.
  - An in-flight transaction is abandoned.

## Timing
- Grant is combinational: mx_gnt_o rises in the same cycle as s_gnt_i. A master's address phase completes in that cycle.
- The response path is combinational: mx_rvalid_o/rdata/err match the s_* signals in the same cycle.
- If a transaction's s_gnt_i lands in cycle T, the earliest next grant is T+2: RESP at T+1 takes an immediate s_rvalid_i, and IDLE at T+2 can grant again.
- Timeout: with a grant in cycle T and no rvalid, the error response appears in cycle T+1+TIMEOUT_CYCLES (T+256 at the default). A real s_rvalid_i in that same cycle takes precedence.
- Masters hold req and all request fields stable until their gnt is seen. The arbiter does not register request fields.

## Test plan
- Single read, master 0: addr=0x1000_0000, gnt in cycle 1, rvalid in cycle 2 with rdata=0xDEADBEEF. Expect m0_gnt_o in cycle 1 and m0_rvalid_o with 0xDEADBEEF in cycle 2. Master 1 outputs stay 0.
- Contention with ROUND_ROBIN=1: both masters request continuously with zero-wait slave. Grants go 0,1,0,1, one per 2 cycles. With ROUND_ROBIN=0, master 1 gets all 4 grants.
- Slave stall: gnt delayed 3 cycles while master 1 requests mid-stall. Owner stays 0, master 1 is granted only after master 0's rvalid. s_addr_o never changes during the stall.
- Timeout, TIMEOUT_CYCLES=4: no rvalid after a gnt in cycle T. Expect m1_rvalid_o=1, m1_err_o=1, rdata=0 in cycle T+5. A later s_rvalid_i at T+7 produces no mx_rvalid_o.
- Owner drops req in ADDR: master 0 req deasserts before gnt. Expect return to IDLE, s_req_o=0, and master 1 is granted next.
- Reset in RESP: assert rst_n=0 mid-transaction. Expect all outputs 0 immediately. After release, the first contended grant goes to master 0 (last=1).
